// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths for fifo_async and its read-side consumers
package fifo_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 4;
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: small circular buffer holding words popped from the FIFO until the sink takes them
module fifo_skid_buf import fifo_pkg::*; #(
   parameter int DW = DATA_WIDTH,
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [CW-1:0] count,
   output logic [DW-1:0] dout
);
   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] head_q, tail_q, head_d, tail_d;
   logic [CW-1:0] count_q, count_d;
   always_comb begin
      head_d  = pop ? ((head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1) : head_q;
      tail_d  = push ? ((tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1) : tail_q;
      count_d = count_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) mem_q[tail_q] <= din;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   assign count = count_q;
   assign dout  = mem_q[head_q];
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops fifo_async and re-presents words as a valid/ready stream,
// absorbing the FIFO's one-cycle read latency so the sink may stall freely.
module fifo_rd_stream import fifo_pkg::*; #(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int BUF_DEPTH  = 2,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  empty,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  pause,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CNT_WIDTH-1:0]  word_cnt,
   output logic                  busy
);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   logic                 pend_q;
   logic [CNT_WIDTH-1:0] word_cnt_q;
   logic [CW-1:0]        count;
   logic [CW:0]          lvl;
   logic                 deq;
   // occupancy after this edge counting the in-flight word, so every pop has a slot reserved
   always_comb begin
      deq     = m_valid && m_ready;
      lvl     = {1'b0, count} + (CW+1)'(pend_q) - (CW+1)'(deq);
      rd_en   = !rd_rst && !empty && !pause && (lvl < (CW+1)'(BUF_DEPTH));
      m_valid = count != '0;
      busy    = pend_q | m_valid;
   end
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         pend_q     <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         pend_q <= rd_en;
         if (deq) word_cnt_q <= word_cnt_q + 1'b1;
      end
   end
   assign word_cnt = word_cnt_q;
   fifo_skid_buf #(.DW(DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
      .clk   (rd_clk),
      .rst   (rd_rst),
      .push  (pend_q),
      .din   (rd_data),
      .pop   (deq),
      .count (count),
      .dout  (m_data)
   );
   a_no_pop_empty: assert property (@(posedge rd_clk) disable iff (rd_rst) !(rd_en && empty));
   a_count_bound:  assert property (@(posedge rd_clk) disable iff (rd_rst) count <= CW'(BUF_DEPTH));
   c_deliver:      cover property (@(posedge rd_clk) m_valid && m_ready);
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: queue-modelled FIFO feeding the DUT; scoreboard expects the stream to equal the write order
module tb_fifo_rd_stream;
   localparam int DW = 8;
   localparam int BD = 2;
   localparam int CNTW = 5;
   logic clk = 1'b0, rd_rst = 1'b1, empty = 1'b1, pause = 1'b0, m_ready = 1'b0;
   logic rd_en, m_valid, busy;
   logic [DW-1:0] rd_data = '0, m_data;
   logic [CNTW-1:0] word_cnt;
   logic [DW-1:0] fifo[$], exp_q[$];
   int n_chk = 0, n_fail = 0, n_deliv = 0;
   logic stall_q = 1'b0;
   logic [DW-1:0] stall_data = '0;

   fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(CNTW)) dut (
      .rd_clk(clk), .rd_rst(rd_rst), .empty(empty), .rd_en(rd_en), .rd_data(rd_data),
      .pause(pause), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .word_cnt(word_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // monitor: ordering, stall stability, delivered count, no pop while empty
   always @(negedge clk) begin
      if (rd_rst) stall_q = 1'b0;
      else begin
         chk("rd_en_while_empty", {31'd0, rd_en & empty}, 0);
         if (stall_q) begin
            chk("stall_valid", {31'd0, m_valid}, 1);
            chk("stall_data", {24'd0, m_data}, {24'd0, stall_data});
         end
         chk("word_cnt", {27'd0, word_cnt}, n_deliv & ((1 << CNTW) - 1));
         if (m_valid && m_ready) begin
            chk("word_expected", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) chk("m_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            n_deliv++;
         end
         stall_q = m_valid && !m_ready;
         stall_data = m_data;
      end
   end

   task automatic wr(input logic [DW-1:0] d);
      fifo.push_back(d);
      exp_q.push_back(d);
      empty = 1'b0;
   endtask

   // one clock: sample DUT mid-cycle, then model the FIFO's registered read after the edge
   task automatic cyc(input bit w, input logic [DW-1:0] d, output bit re, output bit mv, output logic [DW-1:0] md);
      @(negedge clk);
      re = rd_en;
      mv = m_valid;
      md = m_data;
      @(posedge clk);
      #1;
      if (rd_rst) begin
         fifo.delete();
         exp_q.delete();
         n_deliv = 0;
      end else if (re && fifo.size() != 0) rd_data = fifo.pop_front();
      if (w) begin
         fifo.push_back(d);
         exp_q.push_back(d);
      end
      empty = fifo.size() == 0;
   endtask

   task automatic drain(input string nm);
      bit re, mv;
      logic [DW-1:0] md;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(0, '0, re, mv, md);
      chk(nm, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit re, mv;
      logic [DW-1:0] md;
      int cnt, base;
      rd_rst = 1'b1;
      m_ready = 1'b1;
      empty = 1'b0;
      repeat (2) begin
         cyc(0, '0, re, mv, md);
         empty = 1'b0;
         chk("rst_rd_en", {31'd0, re}, 0);
         chk("rst_m_valid", {31'd0, mv}, 0);
         chk("rst_word_cnt", {27'd0, word_cnt}, 0);
         chk("rst_busy", {31'd0, busy}, 0);
      end
      rd_rst = 1'b0;
      for (int i = 0; i < 3; i++) wr(DW'(8'hE0 + i));
      cyc(0, '0, re, mv, md);
      chk("rd_en_after_rst", {31'd0, re}, 1);
      drain("drain_after_rst");

      base = n_deliv;
      for (int i = 1; i <= 16; i++) wr(DW'(i));
      repeat (18) cyc(0, '0, re, mv, md);
      chk("stream_throughput", n_deliv - base, 16);
      drain("drain_stream");

      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(DW'(8'h30 + i));
      cnt = 0;
      repeat (10) begin
         cyc(0, '0, re, mv, md);
         cnt += int'(re);
      end
      chk("bp_pops", cnt, 2);
      chk("bp_head", {24'd0, m_data}, 32'h30);
      m_ready = 1'b1;
      drain("drain_bp");

      wr(8'hA5);
      cyc(0, '0, re, mv, md);
      chk("empty_pop", {31'd0, re}, 1);
      chk("empty_valid0", {31'd0, mv}, 0);
      cyc(0, '0, re, mv, md);
      chk("empty_nopop", {31'd0, re}, 0);
      chk("empty_valid1", {31'd0, mv}, 0);
      cyc(0, '0, re, mv, md);
      chk("empty_valid2", {31'd0, mv}, 1);
      chk("empty_data", {24'd0, md}, 32'hA5);
      repeat (2) cyc(0, '0, re, mv, md);

      for (int i = 0; i < 4; i++) wr(DW'(8'h50 + i));
      cyc(0, '0, re, mv, md);
      chk("pause_first_pop", {31'd0, re}, 1);
      pause = 1'b1;
      base = n_deliv;
      cnt = 0;
      repeat (6) begin
         cyc(0, '0, re, mv, md);
         cnt += int'(re);
      end
      chk("pause_pops", cnt, 0);
      chk("pause_deliv", n_deliv - base, 1);
      pause = 1'b0;
      drain("drain_pause");

      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(DW'(8'h70 + i));
      repeat (2) cyc(0, '0, re, mv, md);
      rd_rst = 1'b1;
      cyc(0, '0, re, mv, md);
      cyc(0, '0, re, mv, md);
      chk("midrst_valid", {31'd0, mv}, 0);
      chk("midrst_busy", {31'd0, busy}, 0);
      chk("midrst_word_cnt", {27'd0, word_cnt}, 0);
      rd_rst = 1'b0;

      for (int i = 0; i < 400; i++) begin
         m_ready = $urandom_range(0, 3) != 0;
         pause = $urandom_range(0, 7) == 0;
         cyc($urandom_range(0, 1) == 1, DW'($urandom), re, mv, md);
      end
      pause = 1'b0;
      m_ready = 1'b1;
      drain("drain_random");
      cyc(0, '0, re, mv, md);
      chk("idle_busy", {31'd0, busy}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
